// File: rtl/me_search_ctrl.sv
// Sequencer for one full-search motion-estimation pass on a pe_row datapath.
// Optional watchdog on the WAIT state is enabled by defining ME_TIMEOUT_EN.
module me_search_ctrl #(
  parameter int BLK_SIZE   = 8,
  parameter int ADDR_W     = 8,
  parameter int REF_ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  cur_rd,
  output logic [ADDR_W-1:0]     cur_addr,
  input  logic [7:0]            cur_data,
  output logic                  refa_rd,
  output logic [REF_ADDR_W-1:0] refa_addr,
  input  logic [7:0]            refa_data,
  output logic                  refb_rd,
  output logic [REF_ADDR_W-1:0] refb_addr,
  input  logic [7:0]            refb_data,
  output logic                  row_reset,
  output logic                  row_start,
  output logic [7:0]            row_c,
  output logic [7:0]            row_p,
  output logic [7:0]            row_p_prime,
  input  logic                  row_done,
  input  logic [7:0]            row_mme,
  input  logic [7:0]            row_mi,
  input  logic [7:0]            row_mj,
  output logic [7:0]            mv_i,
  output logic [7:0]            mv_j,
  output logic [7:0]            best_sad,
  output logic                  err
);

  localparam int LOG = $clog2(BLK_SIZE);
  localparam int K_W = 3 * LOG;
  localparam logic [K_W-1:0] K_LAST = K_W'(BLK_SIZE * BLK_SIZE * BLK_SIZE - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_WAIT, S_FIN} state_t;

  state_t           state, state_nxt;
  logic [K_W-1:0]   k;
  logic [LOG-1:0]   k_x, k_y, k_i;
  logic [REF_ADDR_W-1:0] row_sum, refb_full;
  logic             in_stream;
  logic             wd_expire;
  logic             capture_ok;

  // k is laid out as {i, y, x}, so the decomposition is a pure bit split.
  assign k_x = k[LOG-1:0];
  assign k_y = k[2*LOG-1:LOG];
  assign k_i = k[3*LOG-1:2*LOG];

  assign in_stream = (state == S_STREAM);
  assign busy      = (state != S_IDLE);
  assign row_reset = reset | (state == S_CLEAR);

  always_comb begin
    row_sum   = REF_ADDR_W'(k_y) + REF_ADDR_W'(k_i);
    refb_full = (row_sum << (LOG + 1)) + REF_ADDR_W'(k_x);
  end

  assign cur_rd    = in_stream;
  assign refa_rd   = in_stream;
  assign refb_rd   = in_stream;
  assign cur_addr  = in_stream ? ADDR_W'(k[2*LOG-1:0]) : '0;
  assign refb_addr = in_stream ? refb_full : '0;
  assign refa_addr = in_stream ? refb_full + REF_ADDR_W'(BLK_SIZE) : '0;

  assign row_c       = cur_data;
  assign row_p       = refa_data;
  assign row_p_prime = refb_data;

`ifdef ME_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(2 * BLK_SIZE * BLK_SIZE * BLK_SIZE + 16 - 1);

  logic [15:0] wd;
  logic        timed_out;

  assign wd_expire  = (state == S_WAIT) && !row_done && (wd == WD_LAST);
  assign capture_ok = !timed_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      wd        <= '0;
      timed_out <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (state == S_CLEAR)
        wd <= '0;
      else if (state == S_WAIT)
        wd <= wd + 16'd1;
      if (state == S_IDLE && start) begin
        timed_out <= 1'b0;
        err       <= 1'b0;
      end
      if (wd_expire)
        timed_out <= 1'b1;
      if (state == S_FIN && timed_out)
        err <= 1'b1;
    end
  end
`else
  assign wd_expire  = 1'b0;
  assign capture_ok = 1'b1;
  assign err        = 1'b0;
`endif

  // NOTE: every output and next-state term gets a default first so no path
  // through the case leaves a variable unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_CLEAR;
      S_CLEAR:  state_nxt = S_STREAM;
      S_STREAM: if (k == K_LAST) state_nxt = S_WAIT;
      S_WAIT:   if (row_done || wd_expire) state_nxt = S_FIN;
      S_FIN:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      k         <= '0;
      row_start <= 1'b0;
      done      <= 1'b0;
      mv_i      <= '0;
      mv_j      <= '0;
      best_sad  <= '0;
    end else begin
      state     <= state_nxt;
      // The RAMs have one cycle of latency, so the first beat lands a cycle
      // after k = 0 is addressed.
      row_start <= in_stream && (k == '0);
      done      <= (state == S_FIN);
      if (state == S_CLEAR)
        k <= '0;
      else if (in_stream)
        k <= k + K_W'(1);
      if (state == S_FIN && capture_ok) begin
        mv_i     <= row_mi;
        mv_j     <= row_mj;
        best_sad <= row_mme;
      end
    end
  end

endmodule

// File: tb/tb_me_search_ctrl.sv
// Directed testbench for me_search_ctrl with N = 4; the watchdog scenario
// runs only when ME_TIMEOUT_EN is defined.
module tb_me_search_ctrl;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset, start;
  logic       busy, done;
  logic       cur_rd, refa_rd, refb_rd;
  logic [7:0] cur_addr;
  logic [9:0] refa_addr, refb_addr;
  logic [7:0] cur_data, refa_data, refb_data;
  logic       row_reset, row_start, row_done;
  logic [7:0] row_c, row_p, row_p_prime;
  logic [7:0] row_mme, row_mi, row_mj;
  logic [7:0] mv_i, mv_j, best_sad;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int pass_start;

  me_search_ctrl #(.BLK_SIZE(N), .ADDR_W(8), .REF_ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .cur_rd(cur_rd), .cur_addr(cur_addr), .cur_data(cur_data),
    .refa_rd(refa_rd), .refa_addr(refa_addr), .refa_data(refa_data),
    .refb_rd(refb_rd), .refb_addr(refb_addr), .refb_data(refb_data),
    .row_reset(row_reset), .row_start(row_start),
    .row_c(row_c), .row_p(row_p), .row_p_prime(row_p_prime),
    .row_done(row_done), .row_mme(row_mme), .row_mi(row_mi), .row_mj(row_mj),
    .mv_i(mv_i), .mv_j(mv_j), .best_sad(best_sad), .err(err)
  );

  always #5 clk = ~clk;

  // Block RAM models with distinct content patterns and one cycle of latency.
  function automatic logic [7:0] cur_f(input logic [7:0] a);
    return a + 8'h10;
  endfunction
  function automatic logic [7:0] refa_f(input logic [9:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction
  function automatic logic [7:0] refb_f(input logic [9:0] a);
    return a[7:0] + 8'h33;
  endfunction

  always @(posedge clk) begin
    cur_data  <= cur_f(cur_addr);
    refa_data <= refa_f(refa_addr);
    refb_data <= refb_f(refb_addr);
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick;
      n_tests++; if (row_reset !== 1'b1) begin n_fail++; $display("FAIL reset_row_reset: got %b expected 1", row_reset); end
      n_tests++; if ({busy, done, cur_rd, refa_rd, refb_rd, row_start, err} !== 7'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000000", {busy, done, cur_rd, refa_rd, refb_rd, row_start, err}); end
      n_tests++; if ({cur_addr, refa_addr, refb_addr} !== 28'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", {cur_addr, refa_addr, refb_addr}); end
      n_tests++; if ({mv_i, mv_j, best_sad} !== 24'h0) begin n_fail++; $display("FAIL reset_results: got %h expected 000000", {mv_i, mv_j, best_sad}); end
    end
    reset = 1'b0;
    tick;
    n_tests++; if ({row_reset, busy} !== 2'b00) begin n_fail++; $display("FAIL idle_after_reset: got %b expected 00", {row_reset, busy}); end
  endtask

  task automatic test_start_with_reset;
    reset = 1'b1;
    start = 1'b1;
    tick;
    reset = 1'b0;
    start = 1'b0;
    tick;
    n_tests++; if ({busy, row_reset, cur_rd} !== 3'b000) begin n_fail++; $display("FAIL start_with_reset: got %b expected 000", {busy, row_reset, cur_rd}); end
    tick;
    n_tests++; if ({busy, cur_rd} !== 2'b00) begin n_fail++; $display("FAIL start_with_reset_hold: got %b expected 00", {busy, cur_rd}); end
  endtask

  // Full pass with result capture at cycle 102, stray starts at 10 and 70,
  // and a row_done glitch during STREAM that must be ignored.
  task automatic test_full_pass;
    int beats = 0;
    int dones = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    n_tests++; if ({row_reset, busy, cur_rd} !== 3'b110) begin n_fail++; $display("FAIL clear_cycle: got %b expected 110", {row_reset, busy, cur_rd}); end
    for (int c = 2; c <= 102; c++) begin
      tick;
      if (cur_rd && refa_rd && refb_rd) beats++;
      if (done) dones++;
      if (c == 2) begin
        n_tests++; if ({cur_addr, refa_addr, refb_addr} !== {8'd0, 10'd4, 10'd0}) begin n_fail++; $display("FAIL addr_k0: got %0d/%0d/%0d expected 0/4/0", cur_addr, refa_addr, refb_addr); end
        n_tests++; if (row_start !== 1'b0) begin n_fail++; $display("FAIL row_start_early: got %b expected 0", row_start); end
      end
      if (c == 3) begin
        n_tests++; if (row_start !== 1'b1) begin n_fail++; $display("FAIL row_start: got %b expected 1", row_start); end
        n_tests++; if ({row_c, row_p, row_p_prime} !== {cur_f(8'd0), refa_f(10'd4), refb_f(10'd0)}) begin n_fail++; $display("FAIL first_beat_data: got %h expected %h", {row_c, row_p, row_p_prime}, {cur_f(8'd0), refa_f(10'd4), refb_f(10'd0)}); end
      end
      if (c == 4) begin
        n_tests++; if (row_start !== 1'b0) begin n_fail++; $display("FAIL row_start_pulse: got %b expected 0", row_start); end
      end
      if (c == 11) begin
        n_tests++; if ({cur_addr, refa_addr, refb_addr} !== {8'd9, 10'd21, 10'd17}) begin n_fail++; $display("FAIL addr_k9_after_busy_start: got %0d/%0d/%0d expected 9/21/17", cur_addr, refa_addr, refb_addr); end
      end
      if (c == 23) begin
        n_tests++; if ({cur_addr, refa_addr, refb_addr} !== {8'd5, 10'd21, 10'd17}) begin n_fail++; $display("FAIL addr_k21: got %0d/%0d/%0d expected 5/21/17", cur_addr, refa_addr, refb_addr); end
      end
      if (c == 65) begin
        n_tests++; if ({cur_addr, refa_addr, refb_addr} !== {8'd15, 10'd55, 10'd51}) begin n_fail++; $display("FAIL addr_k63: got %0d/%0d/%0d expected 15/55/51", cur_addr, refa_addr, refb_addr); end
      end
      if (c == 66) begin
        n_tests++; if ({busy, cur_rd, refa_rd, refb_rd} !== 4'b1000) begin n_fail++; $display("FAIL wait_state: got %b expected 1000", {busy, cur_rd, refa_rd, refb_rd}); end
        n_tests++; if ({row_c, row_p, row_p_prime} !== {cur_f(8'd15), refa_f(10'd55), refb_f(10'd51)}) begin n_fail++; $display("FAIL last_beat_data: got %h expected %h", {row_c, row_p, row_p_prime}, {cur_f(8'd15), refa_f(10'd55), refb_f(10'd51)}); end
      end
      if (c == 71) begin
        n_tests++; if ({busy, row_reset} !== 2'b10) begin n_fail++; $display("FAIL busy_start_ignored: got %b expected 10", {busy, row_reset}); end
      end
      if (c == 101) begin
        n_tests++; if ({done, busy} !== 2'b01) begin n_fail++; $display("FAIL fin_cycle: got %b expected 01", {done, busy}); end
      end
      if (c == 102) begin
        n_tests++; if ({done, busy} !== 2'b10) begin n_fail++; $display("FAIL done_cycle: got %b expected 10", {done, busy}); end
        n_tests++; if ({best_sad, mv_i, mv_j} !== 24'h12FE01) begin n_fail++; $display("FAIL capture: got %h expected 12fe01", {best_sad, mv_i, mv_j}); end
      end
      start    = (c == 10) || (c == 70);
      row_done = (c == 40) || (c == 100);
      if (c == 100) begin
        row_mme = 8'h12;
        row_mi  = 8'hFE;
        row_mj  = 8'h01;
      end
    end
    n_tests++; if (beats !== N * N * N) begin n_fail++; $display("FAIL beat_count: got %0d expected %0d", beats, N * N * N); end
    n_tests++; if (dones !== 1) begin n_fail++; $display("FAIL done_count: got %0d expected 1", dones); end
  endtask

  task automatic test_back_to_back;
    tick;
    start      = 1'b1;
    pass_start = cyc;
    tick;
    start = 1'b0;
    n_tests++; if ({row_reset, busy, done} !== 3'b110) begin n_fail++; $display("FAIL back_to_back: got %b expected 110", {row_reset, busy, done}); end
  endtask

  // Aborts the pass begun by test_back_to_back at k = 30, then runs a clean
  // pass with row_done already high, which gives the minimum latency.
  task automatic test_reset_mid_stream;
    int beats = 0;
    int dones = 0;
    int base;
    while (cyc < pass_start + 2 + 30) tick;
    n_tests++; if ({cur_addr, refa_addr, refb_addr} !== {8'd14, 10'd38, 10'd34}) begin n_fail++; $display("FAIL addr_k30: got %0d/%0d/%0d expected 14/38/34", cur_addr, refa_addr, refb_addr); end
    reset = 1'b1;
    tick;
    n_tests++; if ({busy, cur_rd, refa_rd, refb_rd, done, row_reset} !== 6'b000001) begin n_fail++; $display("FAIL mid_reset_state: got %b expected 000001", {busy, cur_rd, refa_rd, refb_rd, done, row_reset}); end
    n_tests++; if ({best_sad, mv_i, mv_j, cur_addr} !== 32'h0) begin n_fail++; $display("FAIL mid_reset_values: got %h expected 0", {best_sad, mv_i, mv_j, cur_addr}); end
    reset = 1'b0;
    tick;
    n_tests++; if ({row_reset, busy} !== 2'b00) begin n_fail++; $display("FAIL mid_reset_release: got %b expected 00", {row_reset, busy}); end
    row_done = 1'b1;
    row_mme  = 8'h34;
    row_mi   = 8'h02;
    row_mj   = 8'hFD;
    start    = 1'b1;
    base     = cyc;
    tick;
    start = 1'b0;
    n_tests++; if ({row_reset, busy} !== 2'b11) begin n_fail++; $display("FAIL clean_pass_clear: got %b expected 11", {row_reset, busy}); end
    while (cyc < base + N * N * N + 4) begin
      tick;
      if (cur_rd) beats++;
      if (done) dones++;
      if (cyc == base + 3) begin
        n_tests++; if (row_start !== 1'b1) begin n_fail++; $display("FAIL clean_row_start: got %b expected 1", row_start); end
      end
      if (cyc == base + N * N * N + 3) begin
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL min_latency_early: got %b expected 0", done); end
      end
    end
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL min_latency_done: got %b expected 1", done); end
    n_tests++; if ({best_sad, mv_i, mv_j} !== 24'h3402FD) begin n_fail++; $display("FAIL clean_capture: got %h expected 3402fd", {best_sad, mv_i, mv_j}); end
    n_tests++; if ({beats, dones} !== {32'd64, 32'd1}) begin n_fail++; $display("FAIL clean_counts: got %0d beats %0d dones expected 64 beats 1 done", beats, dones); end
    row_done = 1'b0;
  endtask

`ifdef ME_TIMEOUT_EN
  // WAIT entered at base+66; 144 WAIT cycles; FIN at base+210; done at base+211.
  task automatic test_timeout;
    int base;
    int dones = 0;
    row_mme = 8'hAA;
    row_mi  = 8'hBB;
    row_mj  = 8'hCC;
    start   = 1'b1;
    base    = cyc;
    tick;
    start = 1'b0;
    while (cyc < base + 211) begin
      tick;
      if (done) dones++;
      if (cyc == base + 210) begin
        n_tests++; if ({done, err} !== 2'b00) begin n_fail++; $display("FAIL timeout_early: got %b expected 00", {done, err}); end
      end
    end
    n_tests++; if ({done, err, dones} !== {1'b1, 1'b1, 32'd1}) begin n_fail++; $display("FAIL timeout_done: got %b/%b/%0d expected 1/1/1", done, err, dones); end
    n_tests++; if ({best_sad, mv_i, mv_j} !== 24'h3402FD) begin n_fail++; $display("FAIL timeout_results_held: got %h expected 3402fd", {best_sad, mv_i, mv_j}); end
    tick;
    n_tests++; if ({err, done} !== 2'b10) begin n_fail++; $display("FAIL err_sticky: got %b expected 10", {err, done}); end
    start = 1'b1;
    tick;
    start    = 1'b0;
    row_done = 1'b1;
    n_tests++; if ({err, busy} !== 2'b01) begin n_fail++; $display("FAIL err_clear: got %b expected 01", {err, busy}); end
    for (int c = 0; c < 70; c++) tick;
    row_done = 1'b0;
    n_tests++; if ({best_sad, busy, err} !== {8'hAA, 1'b0, 1'b0}) begin n_fail++; $display("FAIL post_timeout_pass: got %h/%b/%b expected aa/0/0", best_sad, busy, err); end
  endtask
`endif

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    row_done = 1'b0;
    row_mme  = 8'h00;
    row_mi   = 8'h00;
    row_mj   = 8'h00;
    test_reset;
    test_start_with_reset;
    test_full_pass;
    test_back_to_back;
    test_reset_mid_stream;
`ifdef ME_TIMEOUT_EN
    test_timeout;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
